sn251_scan_ctrl: RTL and testbench
==================================

SN251_SCAN_CTRL -- requirements
Module: sn251_scan_ctrl

Interface
REQ-001 Parameter: DW, 4, width of dwell input and dwell counter.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one scan; accepted only in IDLE.
REQ-005 data  input  8  word to present on the '251 data inputs.
REQ-006 dwell  input  DW  cycles per select value minus 1; sampled at start acceptance.
REQ-007 dir  input  1  scan order: 0 = sel 0->7, 1 = sel 7->0; sampled at start acceptance.
REQ-008 mux_a  output  8  drives '251 a[7:0].
REQ-009 mux_sel  output  3  drives '251 sel[2:0].
REQ-010 mux_oe  output  1  drives '251 strobe/oe; 1 = outputs disabled (high-Z), 0 = enabled.
REQ-011 mux_y  input  1  '251 out.
REQ-012 mux_yn  input  1  '251 _out.
REQ-013 busy  output  1  high from start acceptance through the DONE cycle.
REQ-014 done  output  1  one-cycle pulse at scan completion.
REQ-015 rx  output  8  word reassembled from sampled mux_y, bit index = sel at sample time.
REQ-016 err  output  1  sticky mismatch flag for the current or last scan.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, SCAN, DONE.
REQ-018 IDLE with start=1: next edge -> SETUP; latch data into mux_a, dwell and dir into internal registers; mux_sel = 0 (dir=0) or 7 (dir=1); busy=1; clear rx and err.
REQ-019 start while busy (SETUP/SCAN/DONE) SHALL be ignored with no effect on state or outputs.
REQ-020 SETUP SHALL last exactly 1 cycle with mux_oe=1, then go to SCAN.
REQ-021 SCAN: mux_oe=0; each sel value held dwell+1 cycles by a down-counter loaded with dwell.
REQ-022 On the final cycle of each sel value, the edge SHALL capture rx[mux_sel] <= mux_y.
REQ-023 Same edge SHALL set err if mux_y == mux_yn or mux_y != mux_a[mux_sel]; err never cleared except by rst or start acceptance.
REQ-024 After capture, sel SHALL advance +1 (dir=0) or -1 (dir=1); after the 8th capture (sel 7 for dir=0, sel 0 for dir=1), no wrap; go to DONE.
REQ-025 DONE SHALL last 1 cycle: mux_oe=1, done=1, busy=1; then IDLE with busy=0.
REQ-026 In IDLE: mux_oe=1, done=0; mux_a, mux_sel, rx, err hold last values.
REQ-027 Latency: done asserted in cycle 2 + 8*(dwell+1) counting the start-acceptance edge as cycle 0 (dwell=0 -> cycle 10; dwell=15 -> cycle 130).
REQ-028 dwell=0 SHALL give one cycle per sel value; dwell = all ones SHALL give 2^DW cycles, counter with no overflow.
REQ-029 start held high continuously SHALL start a new scan on the cycle after DONE (back-to-back, one IDLE cycle).
REQ-030 mux_oe SHALL never be 0 outside SCAN.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, mux_oe=1, mux_sel=0, mux_a=0, busy=0, done=0, rx=0, err=0, counters 0, regardless of state; rst has priority over start.
REQ-032 Reset mid-scan SHALL abort with no done pulse; first start after rst deasserts behaves per REQ-018.

Verification
REQ-033 Ideal '251 model (y=a[sel], yn=~y, high-Z when oe=1), data=A5, dwell=0, dir=0 -> sel 0..7 one cycle each, mux_oe low 8 cycles, done at cycle 10, rx=A5, err=0.
REQ-034 data=3C, dwell=3, dir=1 -> sel 7..0 four cycles each, done at cycle 34, rx=3C, err=0.
REQ-035 data=A5 with mux_y stuck 0 -> err=1 after first sample of sel 0, rx=00 at done.
REQ-036 mux_yn tied to mux_y, data=FF -> err=1, rx=FF.
REQ-037 start pulsed again at cycle 4 of a scan -> ignored, single done; rst at sel=4 -> next cycle all REQ-031 values, no done; new start completes normally.

Source files
------------

// File: rtl/sn251_scan_ctrl.sv
// sn251_scan_ctrl: drives a '251 8:1 mux through all select values and
// reassembles the sampled output word, flagging any y/yn or data mismatch.
module sn251_scan_ctrl #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    data,
    input  logic [DW-1:0] dwell,
    input  logic          dir,
    output logic [7:0]    mux_a,
    output logic [2:0]    mux_sel,
    output logic          mux_oe,
    input  logic          mux_y,
    input  logic          mux_yn,
    output logic          busy,
    output logic          done,
    output logic [7:0]    rx,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;
    state_t state, nxt;
    logic [DW-1:0] dwell_r, cnt;
    logic dir_r, tick, last_sel, accept;
    always_comb begin
        tick     = cnt == '0;
        last_sel = dir_r ? mux_sel == 3'd0 : mux_sel == 3'd7;
        accept   = state == IDLE && start;
        nxt      = state == IDLE  ? (start ? SETUP : IDLE) :
                   state == SETUP ? SCAN :
                   state == SCAN  ? (tick && last_sel ? DONE : SCAN) : IDLE;
        mux_oe   = state != SCAN;
        busy     = state != IDLE;
        done     = state == DONE;
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    // the select value is held dwell+1 cycles; capture happens on its last cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_a   <= '0;
            mux_sel <= '0;
            dwell_r <= '0;
            dir_r   <= 1'b0;
            cnt     <= '0;
            rx      <= '0;
            err     <= 1'b0;
        end else if (accept) begin
            mux_a   <= data;
            mux_sel <= dir ? 3'd7 : 3'd0;
            dwell_r <= dwell;
            dir_r   <= dir;
            cnt     <= dwell;
            rx      <= '0;
            err     <= 1'b0;
        end else if (state == SCAN) begin
            if (tick) begin
                rx[mux_sel] <= mux_y;
                if (mux_y == mux_yn || mux_y != mux_a[mux_sel])
                    err <= 1'b1;
                cnt <= dwell_r;
                if (!last_sel)
                    mux_sel <= dir_r ? mux_sel - 3'd1 : mux_sel + 3'd1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sn251_scan_ctrl.sv
// tb_sn251_scan_ctrl: randomized and directed scans against a '251 device
// model and a per-cycle reference of the expected scan sequence.
module tb_sn251_scan_ctrl;
    logic clk = 1'b0;
    logic rst, start, dir;
    logic [7:0] data;
    logic [3:0] dwell;
    logic [7:0] mux_a, rx;
    logic [2:0] mux_sel;
    logic mux_oe, mux_y, mux_yn, busy, done, err, y_v;
    int tests = 0, fails = 0;
    int mode = 0;

    sn251_scan_ctrl #(.DW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .dwell(dwell), .dir(dir),
        .mux_a(mux_a), .mux_sel(mux_sel), .mux_oe(mux_oe), .mux_y(mux_y),
        .mux_yn(mux_yn), .busy(busy), .done(done), .rx(rx), .err(err)
    );

    always #5 clk = ~clk;

    // '251 device: mode 0 ideal, 1 output stuck low, 2 yn shorted to y
    assign y_v    = mode == 1 ? 1'b0 : mux_a[mux_sel];
    assign mux_y  = mux_oe ? 1'bz : y_v;
    assign mux_yn = mux_oe ? 1'bz : (mode == 2 ? y_v : ~y_v);

    task automatic scan(input logic [7:0] d, input logic [3:0] dw, input logic dr,
                        input int md, input bit pulse4);
        int per, n_last, k;
        logic [2:0] sel_m;
        logic err_m;
        logic [7:0] rx_m;
        per = int'(dw) + 1;
        n_last = 2 + 8 * per;
        rx_m = md == 1 ? 8'h00 : d;
        err_m = 1'b0;
        mode = md;
        @(negedge clk);
        start = 1; data = d; dwell = dw; dir = dr;
        @(negedge clk);
        start = 0; data = 8'($urandom); dwell = 4'($urandom); dir = 1'($urandom);
        for (int n = 1; n <= n_last; n++) begin
            tests++;
            if (busy !== 1'b1) begin fails++; $display("FAIL busy c%0d got %b want 1", n, busy); end
            if (n == 1) begin
                tests++;
                if (mux_oe !== 1'b1 || done !== 1'b0 || mux_sel !== (dr ? 3'd7 : 3'd0) || mux_a !== d || rx !== 8'h00 || err !== 1'b0) begin
                    fails++; $display("FAIL setup oe=%b done=%b sel=%0d a=%h rx=%h err=%b", mux_oe, done, mux_sel, mux_a, rx, err);
                end
            end else if (n < n_last) begin
                k = (n - 2) / per;
                sel_m = dr ? 3'(7 - k) : 3'(k);
                tests++;
                if (mux_oe !== 1'b0 || mux_sel !== sel_m || done !== 1'b0 || err !== err_m) begin
                    fails++; $display("FAIL scan c%0d oe=%b sel=%0d done=%b err=%b want sel=%0d err=%b", n, mux_oe, mux_sel, done, err, sel_m, err_m);
                end
                if ((n - 2) % per == per - 1 && (md == 2 || (md == 1 && d[sel_m])))
                    err_m = 1'b1;
            end else begin
                tests++;
                if (done !== 1'b1 || mux_oe !== 1'b1 || rx !== rx_m || err !== err_m) begin
                    fails++; $display("FAIL done_cycle c%0d done=%b oe=%b rx=%h err=%b want rx=%h err=%b", n, done, mux_oe, rx, err, rx_m, err_m);
                end
            end
            if (pulse4) start = (n == 4);
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || mux_oe !== 1'b1 || rx !== rx_m || err !== err_m || mux_a !== d) begin
            fails++; $display("FAIL idle_after busy=%b done=%b oe=%b rx=%h err=%b a=%h want rx=%h err=%b a=%h", busy, done, mux_oe, rx, err, mux_a, rx_m, err_m, d);
        end
    endtask

    task automatic check_reset_vals(input string name);
        tests++;
        if (mux_oe !== 1'b1 || mux_sel !== 3'd0 || mux_a !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || rx !== 8'h00 || err !== 1'b0) begin
            fails++; $display("FAIL %s oe=%b sel=%0d a=%h busy=%b done=%b rx=%h err=%b want 1/0/00/0/0/00/0", name, mux_oe, mux_sel, mux_a, busy, done, rx, err);
        end
    endtask

    task automatic test_reset;
        rst = 1; start = 1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        start = 0; rst = 0;
        @(negedge clk);
        check_reset_vals("reset_idle");
    endtask

    task automatic test_basic;
        scan(8'hA5, 4'd0, 1'b0, 0, 0);
        scan(8'h3C, 4'd3, 1'b1, 0, 0);
    endtask

    task automatic test_faults;
        scan(8'hA5, 4'd0, 1'b0, 1, 0);
        scan(8'hFF, 4'd0, 1'b0, 2, 0);
        scan(8'h5A, 4'd2, 1'b1, 0, 0);
    endtask

    task automatic test_ignore_start;
        scan(8'hA5, 4'd2, 1'b0, 0, 1);
        scan(8'h81, 4'd0, 1'b1, 0, 1);
    endtask

    task automatic test_reset_mid;
        int c;
        bit seen;
        mode = 0;
        @(negedge clk);
        start = 1; data = 8'h5A; dwell = 4'd1; dir = 0;
        @(negedge clk);
        start = 0;
        c = 0;
        while (!(mux_sel == 3'd4 && mux_oe == 1'b0) && c < 50) begin @(negedge clk); c++; end
        tests++;
        if (c >= 50) begin fails++; $display("FAIL mid_wait sel=%0d oe=%b never reached sel 4", mux_sel, mux_oe); end
        rst = 1; start = 1;
        @(negedge clk);
        check_reset_vals("reset_mid");
        rst = 0; start = 0;
        seen = 0;
        repeat (20) begin @(negedge clk); if (done) seen = 1; end
        tests++;
        if (seen !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", seen); end
        scan(8'hC3, 4'd2, 1'b1, 0, 0);
    endtask

    task automatic test_back_to_back;
        int c;
        mode = 0;
        @(negedge clk);
        start = 1; data = 8'h96; dwell = 4'd0; dir = 0;
        c = 0;
        do begin @(negedge clk); c++; end while (!done && c < 200);
        tests++;
        if (c != 10) begin fails++; $display("FAIL b2b_latency got %0d want 10", c); end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rx !== 8'h96) begin fails++; $display("FAIL b2b_idle busy=%b rx=%h want 0 96", busy, rx); end
        data = 8'h69; dwell = 4'd1; dir = 1;
        @(negedge clk);
        start = 0;
        tests++;
        if (busy !== 1'b1 || mux_oe !== 1'b1 || mux_a !== 8'h69 || mux_sel !== 3'd7 || rx !== 8'h00 || err !== 1'b0) begin
            fails++; $display("FAIL b2b_setup busy=%b oe=%b a=%h sel=%0d rx=%h err=%b", busy, mux_oe, mux_a, mux_sel, rx, err);
        end
        c = 1;
        while (!done && c < 200) begin @(negedge clk); c++; end
        tests++;
        if (c != 18 || rx !== 8'h69 || err !== 1'b0) begin
            fails++; $display("FAIL b2b_second cycle=%0d rx=%h err=%b want 18 69 0", c, rx, err);
        end
    endtask

    task automatic test_boundary;
        scan(8'hE7, 4'd15, 1'b0, 0, 0);
        scan(8'h18, 4'd15, 1'b1, 2, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++)
            scan(8'($urandom), 4'($urandom_range(0, 5)), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    endtask

    initial begin
        rst = 1; start = 0; data = 0; dwell = 0; dir = 0;
        test_reset;
        test_basic;
        test_faults;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        test_boundary;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
